fmul_share_arb: RTL and testbench

//  Shares one single-precision float multiplier core among NUM_REQ requesters.

---
 rtl/fmul_share_arb_pkg.sv | 15 +
 rtl/fmul_share_arb_if.sv | 29 ++
 rtl/fmul_share_arb_core.sv | 19 +
 rtl/fmul_share_arb.sv | 84 ++++++++
 tb/tb_fmul_share_arb.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/fmul_share_arb_pkg.sv
// fmul_share_arb_pkg: shared fp32 types and constants (package fmul_pkg) for the multiplier core and its arbiter.
//   FP32_W      word width of a single-precision float
//   FP_EXP_BIAS exponent bias
//   FP_ZERO     the only encoding treated as zero (+0)
//   fp32_t      raw single-precision word
//   fp32_is_zero true only for +0; -0 (0x80000000) is deliberately not zero
package fmul_pkg;
    localparam int          FP32_W      = 32;
    localparam logic [7:0]  FP_EXP_BIAS = 8'd127;
    localparam logic [31:0] FP_ZERO     = 32'h0;
    typedef logic [FP32_W-1:0] fp32_t;
    function automatic logic fp32_is_zero(fp32_t x);
        return x == FP_ZERO;
    endfunction
endpackage

// File: rtl/fmul_share_arb_if.sv
// fmul_share_arb_if: operand request and result response bundle of the shared multiplier.
//   req_valid/req_ready  per-requester handshake (ready is a one-hot grant)
//   req_a/req_b          operands, requester i at [32*i+:32]
//   rsp_valid/rsp_ready  result handshake
//   rsp_id/rsp_data      requester tag and product
//   busy                 any operation in flight
//   master: requester/consumer side, slave: the arbiter
interface fmul_share_arb_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*32-1:0] req_a;
    logic [NUM_REQ*32-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [31:0]           rsp_data;
    logic                  busy;
    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, busy
    );
    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, busy
    );
endinterface

// File: rtl/fmul_share_arb_core.sv
// fmul_core: combinational truncating fp32 multiply (no rounding, no NaN/Inf/denormal handling, exponent wraps).
//   a_i, b_i  operands
//   p_o       product; +0 on either input forces +0
module fmul_core
    import fmul_pkg::*;
(
    input  fp32_t a_i,
    input  fp32_t b_i,
    output fp32_t p_o
);
    logic [47:0] prod;
    logic [7:0]  exp_s;
    logic [22:0] frac;
    assign prod  = {24'd0, 1'b1, a_i[22:0]} * {24'd0, 1'b1, b_i[22:0]};
    // Normalising a product in [2,4) takes one extra exponent step.
    assign exp_s = a_i[30:23] + b_i[30:23] - (prod[47] ? FP_EXP_BIAS - 8'd1 : FP_EXP_BIAS);
    assign frac  = prod[47] ? prod[46:24] : prod[45:23];
    assign p_o   = (fp32_is_zero(a_i) || fp32_is_zero(b_i)) ? FP_ZERO : {a_i[31] ^ b_i[31], exp_s, frac};
endmodule

// File: rtl/fmul_share_arb.sv
// fmul_share_arb: round-robin arbiter sharing one fp32 multiplier across NUM_REQ requesters, 2-stage pipeline.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; discards in-flight operations
//   bus    fmul_share_arb_if.slave (requests in, tagged results out)
// Define FMUL_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, no round-robin pointer).
module fmul_share_arb
    import fmul_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fmul_share_arb_if.slave      bus
);
    logic            s1_en, s2_en, gnt_v;
    logic [ID_W-1:0] gnt_id, base, idx;
    logic            s1_v_q, s2_v_q;
    fp32_t           s1_a_q, s1_b_q, s2_p_q, prod;
    logic [ID_W-1:0] s1_id_q, s2_id_q;

    assign s2_en = !s2_v_q || bus.rsp_ready;
    assign s1_en = !s1_v_q || s2_en;

`ifdef FMUL_ARB_FIXED_PRIO_EN
    assign base = '0;
`else
    logic [ID_W-1:0] rr_ptr_q;
    assign base = rr_ptr_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_ptr_q <= '0;
        else if (gnt_v) rr_ptr_q <= ID_W'((int'(gnt_id) + 1) % NUM_REQ);
    end
`endif

    // Scan upward from base with wrap; the first valid requester wins.
    always_comb begin
        gnt_v  = 1'b0;
        gnt_id = '0;
        idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((int'(base) + k) % NUM_REQ);
            if (!gnt_v && bus.req_valid[idx]) begin
                gnt_v  = 1'b1;
                gnt_id = idx;
            end
        end
        // Reset is folded in so no grant is shown while the pipe is held cleared.
        gnt_v = gnt_v && s1_en && rst_n;
    end

    assign bus.req_ready = gnt_v ? NUM_REQ'(1) << gnt_id : '0;

    fmul_core u_core (.a_i(s1_a_q), .b_i(s1_b_q), .p_o(prod));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q  <= 1'b0;
            s1_a_q  <= FP_ZERO;
            s1_b_q  <= FP_ZERO;
            s1_id_q <= '0;
            s2_v_q  <= 1'b0;
            s2_p_q  <= FP_ZERO;
            s2_id_q <= '0;
        end else begin
            if (s1_en) s1_v_q <= gnt_v;
            if (gnt_v) begin
                s1_a_q  <= bus.req_a[FP32_W*int'(gnt_id) +: FP32_W];
                s1_b_q  <= bus.req_b[FP32_W*int'(gnt_id) +: FP32_W];
                s1_id_q <= gnt_id;
            end
            if (s2_en) s2_v_q <= s1_v_q;
            if (s2_en && s1_v_q) begin
                s2_p_q  <= prod;
                s2_id_q <= s1_id_q;
            end
        end
    end

    assign bus.rsp_valid = s2_v_q;
    assign bus.rsp_id    = s2_id_q;
    assign bus.rsp_data  = s2_p_q;
    assign bus.busy      = s1_v_q || s2_v_q;
endmodule

// File: tb/tb_fmul_share_arb.sv
// tb_fmul_share_arb: directed and randomized checks of fmul_share_arb against a queue-based behavioural model.
module tb_fmul_share_arb;
    localparam int N = 4;

    typedef struct {
        int          id;
        logic [31:0] data;
        int          age;
    } op_t;

    logic clk, rst_n;
    int   errs, checks;
    op_t  q[$];
    int   ptr;

    fmul_share_arb_if #(.NUM_REQ(N)) bus ();
    fmul_share_arb #(.NUM_REQ(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference multiply: exact mantissa product, renormalise once if it lands in [2,4), truncate.
    function automatic logic [31:0] fmul_m(logic [31:0] a, logic [31:0] b);
        longint unsigned p;
        int              e;
        logic [31:0]     f;
        if (a == 32'h0 || b == 32'h0) return 32'h0;
        p = (64'(a[22:0]) + (64'd1 << 23)) * (64'(b[22:0]) + (64'd1 << 23));
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p >= (64'd1 << 47)) begin
            p = p >> 1;
            e++;
        end
        f = 32'((p >> 23) & 64'h7F_FFFF);
        return {a[31] ^ b[31], 8'(e), f[22:0]};
    endfunction

    function automatic int gid(int i);
`ifdef FMUL_ARB_FIXED_PRIO_EN
        return 0 * i;
`else
        return i % N;
`endif
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: in-flight ops in grant order; at most two fit unless the head drains this cycle.
    always @(negedge clk) begin : model
        int          base, g, r;
        logic [31:0] exp_rdy;
        logic        exp_v;
        if (!rst_n) begin
            q.delete();
            ptr = 0;
            chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
            chk("rst_busy", 32'(bus.busy), 0);
            chk("rst_req_ready", 32'(bus.req_ready), 0);
        end else begin
`ifdef FMUL_ARB_FIXED_PRIO_EN
            base = 0;
`else
            base = ptr;
`endif
            g = -1;
            if (q.size() < 2 || bus.rsp_ready)
                for (int k = 0; k < N; k++) begin
                    r = (base + k) % N;
                    if (g < 0 && bus.req_valid[r]) g = r;
                end
            exp_rdy = (g < 0) ? 32'h0 : 32'h1 << g;
            chk("grant", 32'(bus.req_ready), exp_rdy);
            exp_v = q.size() > 0 && q[0].age >= 2;
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_v));
            if (exp_v) begin
                chk("rsp_id", 32'(bus.rsp_id), q[0].id);
                chk("rsp_data", bus.rsp_data, q[0].data);
            end
            chk("busy", 32'(bus.busy), 32'(q.size() > 0));
            if (exp_v && bus.rsp_ready) void'(q.pop_front());
            foreach (q[i]) q[i].age++;
            if (g >= 0) begin
                q.push_back('{id: g, data: fmul_m(bus.req_a[32*g +: 32], bus.req_b[32*g +: 32]), age: 1});
                ptr = (g + 1) % N;
            end
        end
    end

    task automatic one(string nm, int r, logic [31:0] a, logic [31:0] b, logic [31:0] exp);
        bus.req_valid = N'(1 << r);
        bus.req_a[32*r +: 32] = a;
        bus.req_b[32*r +: 32] = b;
        @(negedge clk);
        chk({nm, "_grant"}, 32'(bus.req_ready), 32'(1 << r));
        step();
        bus.req_valid = '0;
        @(negedge clk);
        chk({nm, "_lat1"}, 32'(bus.rsp_valid), 0);
        step();
        @(negedge clk);
        chk({nm, "_valid"}, 32'(bus.rsp_valid), 1);
        chk({nm, "_id"}, 32'(bus.rsp_id), r);
        chk({nm, "_data"}, bus.rsp_data, exp);
        step();
    endtask

    initial begin
        logic [31:0] d0;
        int          nrsp;
        errs = 0;
        checks = 0;
        rst_n = 1'b0;
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        bus.req_valid = '1;
        @(negedge clk);
        chk("reset_rsp_data", bus.rsp_data, 0);
        chk("reset_rsp_id", 32'(bus.rsp_id), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.req_valid = '0;

        one("t1_2x3", 0, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000);
        one("t2_1p5sq", 1, 32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000);
        one("t3_zero", 2, 32'h0000_0000, 32'h4040_0000, 32'h0000_0000);
        one("t3_negzero", 3, 32'h8000_0000, 32'h4000_0000, 32'h8080_0000);

        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) begin
            bus.req_a[32*i +: 32] = 32'h3F80_0000 + (i << 20);
            bus.req_b[32*i +: 32] = 32'h4000_0000 + (i << 21);
        end
        bus.req_valid = '1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i < 5) chk("t4_grant_order", 32'(bus.req_ready), 32'(1 << gid(i)));
            if (i >= 2) begin
                chk("t4_rsp_valid", 32'(bus.rsp_valid), 1);
                chk("t4_rsp_id", 32'(bus.rsp_id), gid(i - 2));
            end
            step();
        end

        bus.rsp_ready = 1'b0;
        d0 = '0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            chk("t5_stall_ready", 32'(bus.req_ready), 0);
            chk("t5_stall_id", 32'(bus.rsp_id), gid(5));
            if (j == 0) d0 = bus.rsp_data;
            else chk("t5_stall_data", bus.rsp_data, d0);
            step();
        end
        bus.rsp_ready = 1'b1;
        bus.req_valid = '0;
        @(negedge clk);
        chk("t5_drain0_id", 32'(bus.rsp_id), gid(5));
        chk("t5_drain0_data", bus.rsp_data, d0);
        step();
        @(negedge clk);
        chk("t5_drain1_valid", 32'(bus.rsp_valid), 1);
        chk("t5_drain1_id", 32'(bus.rsp_id), gid(6));
        step();
        @(negedge clk);
        chk("t5_drained", 32'(bus.rsp_valid), 0);
        step();

        bus.req_valid = N'(3);
        repeat (2) step();
        bus.req_valid = '0;
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", 32'(bus.rsp_valid), 0);
        chk("t6_async_busy", 32'(bus.busy), 0);
        repeat (2) step();
        rst_n = 1'b1;
        bus.req_valid = '1;
        @(negedge clk);
        chk("t6_ptr_reset", 32'(bus.req_ready), 1);
        step();
        bus.req_valid = '0;
        nrsp = 0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            if (bus.rsp_valid) nrsp++;
            step();
        end
        chk("t6_no_stale", nrsp, 1);

        for (int c = 0; c < 3000; c++) begin
            bus.req_valid = N'($urandom);
            for (int i = 0; i < N; i++) begin
                bus.req_a[32*i +: 32] = ($urandom % 8 == 0) ? 32'h0 : $urandom;
                bus.req_b[32*i +: 32] = ($urandom % 8 == 0) ? 32'h0 : $urandom;
            end
            bus.rsp_ready = ($urandom % 4) != 0;
            step();
        end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        repeat (4) step();
        @(negedge clk);
        chk("final_drain", q.size(), 0);
        chk("final_busy", 32'(bus.busy), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
